// File: rtl/spi_reg_bridge_if.sv
// Signal bundle between the SPI slave byte interface, the register bus and the bridge.
// The bridge uses the slave modport; the surrounding logic (or a bench) uses master.
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 7
);
    logic              ssel;
    logic              byte_received;
    logic [7:0]        rx_data;
    logic              data_needed;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              underrun;

    modport slave (
        input  ssel, byte_received, rx_data, data_needed, reg_rdata,
        output tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, underrun
    );

    modport master (
        output ssel, byte_received, rx_data, data_needed, reg_rdata,
        input  tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, underrun
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// Parses SPI frames (command byte + data bytes) into register-bus writes and reads;
// read data is prefetched into tx_data ahead of the next byte shift.
module spi_reg_bridge #(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input logic             clk,
    input logic             rst_n,
    spi_reg_bridge_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_READ    = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_data;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_we;
    logic              r_reg_re;
    logic              r_underrun;
    logic              r_ssel_q;
    logic              r_dn_q;

    logic [ADDR_W-1:0] w_rx_addr;
    logic              w_dn_fall;
    logic              w_fetching;

    assign w_rx_addr  = bus.rx_data[ADDR_W-1:0];
    assign w_dn_fall  = r_dn_q & ~bus.data_needed;
    assign w_fetching = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_tx_data   <= STATUS_BYTE;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_underrun  <= 1'b0;
            r_ssel_q    <= 1'b0;
            r_dn_q      <= 1'b0;
        end else begin
            r_ssel_q   <= bus.ssel;
            r_dn_q     <= bus.data_needed;
            r_reg_we   <= 1'b0;
            r_reg_re   <= 1'b0;
            r_underrun <= w_dn_fall && w_fetching;
            if (bus.ssel) begin
                r_state   <= S_IDLE;
                r_tx_data <= STATUS_BYTE;
            end else begin
                case (r_state)
                    // A frame starts only on a seen falling edge, so a reset released
                    // mid-frame stays idle until the master reselects.
                    S_IDLE: begin
                        if (r_ssel_q) begin
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (bus.byte_received) begin
                            r_addr <= w_rx_addr;
                            if (bus.rx_data[7]) begin
                                r_state <= S_WRITE;
                            end else begin
                                r_state    <= S_RD_REQ;
                                r_reg_re   <= 1'b1;
                                r_reg_addr <= w_rx_addr;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (bus.byte_received) begin
                            r_reg_we    <= 1'b1;
                            r_reg_addr  <= r_addr;
                            r_reg_wdata <= bus.rx_data;
                            r_addr      <= r_addr + ADDR_W'(1);
                        end
                    end
                    S_RD_REQ: begin
                        r_state <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        r_tx_data <= bus.reg_rdata;
                        r_addr    <= r_addr + ADDR_W'(1);
                        r_state   <= S_READ;
                    end
                    S_READ: begin
                        if (bus.byte_received) begin
                            r_state    <= S_RD_REQ;
                            r_reg_re   <= 1'b1;
                            r_reg_addr <= r_addr;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_we    = r_reg_we;
    assign bus.reg_re    = r_reg_re;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.underrun  = r_underrun;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: a frame-level model predicts register strobes
// and read-back bytes, and a monitor compares them against the bus as they appear.
module tb_spi_reg_bridge;
    localparam int         ADDR_W    = 7;
    localparam int         ADDR_SPAN = 1 << ADDR_W;
    localparam logic [7:0] STATUS    = 8'hA5;
    localparam int         BYTE_GAP  = 10;

    typedef struct {
        bit         isWrite;
        int         addr;
        logic [7:0] data;
        bit         chkTx;
    } expT;

    logic clk;
    logic rst_n;

    spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    spi_reg_bridge #(
        .ADDR_W      (ADDR_W),
        .STATUS_BYTE (STATUS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    expT        expQ[$];
    logic [7:0] refMem[ADDR_SPAN];
    logic [7:0] busMem[ADDR_SPAN];
    bit         memReady = 1'b0;
    bit         cmdSeen = 1'b0;
    bit         frameWrite = 1'b0;
    int         nextAddr = 0;
    bit         checkTxEnable = 1'b1;
    expT        monE;
    int         pendCnt = 0;
    logic [7:0] pendTx = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] initVal(input int i);
        return 8'((i * 73 + 29) & 255);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Register file on the far side of the bus: read data valid exactly one cycle after reg_re.
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < ADDR_SPAN; i++) busMem[i] <= initVal(i);
            memReady <= 1'b1;
        end else if (bus.reg_we) begin
            busMem[bus.reg_addr] <= bus.reg_wdata;
        end
        if (bus.reg_re) bus.reg_rdata <= busMem[bus.reg_addr];
        else            bus.reg_rdata <= 8'($urandom);
    end

    // Monitor: every strobe consumes one expectation; reads also schedule a tx_data check.
    always @(negedge clk) begin
        if (!rst_n) begin
            pendCnt <= 0;
        end else begin
            if (pendCnt > 0) begin
                pendCnt = pendCnt - 1;
                if (pendCnt == 0) checkOutput("tx_readback", bus.tx_data, pendTx);
            end
            if (bus.reg_we || bus.reg_re) begin
                if (bus.reg_we && bus.reg_re) checkOutput("we_re_exclusive", 2'b11, 2'b00);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", {bus.reg_we, bus.reg_re}, 2'b00);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("strobe_kind", {bus.reg_we, bus.reg_re}, monE.isWrite ? 2'b10 : 2'b01);
                    checkOutput("strobe_addr", bus.reg_addr, monE.addr);
                    if (monE.isWrite) begin
                        checkOutput("write_data", bus.reg_wdata, monE.data);
                        checkOutput("tx_status_on_write", bus.tx_data, STATUS);
                    end else if (monE.chkTx) begin
                        pendTx  = monE.data;
                        pendCnt = 2;
                    end
                end
            end
        end
    end

    task automatic pushRead();
        expT e;
        e.isWrite = 1'b0;
        e.addr    = nextAddr;
        e.data    = refMem[nextAddr];
        e.chkTx   = checkTxEnable;
        expQ.push_back(e);
        nextAddr = (nextAddr + 1) % ADDR_SPAN;
    endtask

    // Frame-level model: first byte picks direction and start address, later bytes walk it.
    task automatic pushExpect(input logic [7:0] b);
        expT e;
        if (!cmdSeen) begin
            cmdSeen    = 1'b1;
            frameWrite = b[7];
            nextAddr   = int'(b) % ADDR_SPAN;
            if (!frameWrite) pushRead();
        end else if (frameWrite) begin
            e.isWrite = 1'b1;
            e.addr    = nextAddr;
            e.data    = b;
            e.chkTx   = 1'b0;
            expQ.push_back(e);
            refMem[nextAddr] = b;
            nextAddr = (nextAddr + 1) % ADDR_SPAN;
        end else begin
            pushRead();
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_data       = b;
        bus.byte_received = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_received = 1'b0;
        bus.rx_data       = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        pushExpect(b);
        sendByte(b);
        repeat (BYTE_GAP) @(posedge clk);
    endtask

    task automatic frameStart();
        #1;
        bus.ssel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_rise", bus.busy, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    task automatic frameEnd(input int gap);
        @(posedge clk);
        #1;
        bus.ssel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_fall", bus.busy, 1'b0);
        checkOutput("tx_idle_status", bus.tx_data, STATUS);
        cmdSeen = 1'b0;
        repeat (gap - 1) @(posedge clk);
    endtask

    initial begin
        int n;
        int pulses;
        logic [7:0] cmd;

        rst_n             = 1'b0;
        bus.ssel          = 1'b1;
        bus.byte_received = 1'b0;
        bus.rx_data       = 8'h00;
        bus.data_needed   = 1'b0;
        for (int i = 0; i < ADDR_SPAN; i++) refMem[i] = initVal(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_tx", bus.tx_data, STATUS);
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_we_re", {bus.reg_we, bus.reg_re}, 2'b00);
        checkOutput("reset_underrun", bus.underrun, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] write burst");
        frameStart();
        applyStimulus(8'h85); applyStimulus(8'h11); applyStimulus(8'h22);
        frameEnd(2);

        $display("[TB] read burst");
        frameStart();
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h4D);
        frameEnd(1);
        frameStart();
        applyStimulus(8'h10); applyStimulus(8'h00); applyStimulus(8'h00);
        frameEnd(1);

        $display("[TB] address wrap");
        frameStart();
        applyStimulus(8'hFF); applyStimulus(8'($urandom)); applyStimulus(8'($urandom));
        frameEnd(2);
        frameStart();
        applyStimulus(8'h7F); applyStimulus(8'h00);
        frameEnd(2);

        $display("[TB] abort in fetch");
        frameStart();
        applyStimulus(8'hA0); applyStimulus(8'h5A);
        frameEnd(2);
        frameStart();
        checkTxEnable = 1'b0;
        pushExpect(8'h20);
        sendByte(8'h20);
        checkTxEnable = 1'b1;
        @(posedge clk);
        #1 bus.ssel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_tx", bus.tx_data, STATUS);
        cmdSeen = 1'b0;
        frameStart();
        applyStimulus(8'hC4); applyStimulus(8'($urandom));
        frameEnd(2);

        $display("[TB] underrun");
        frameStart();
        bus.data_needed = 1'b1;
        repeat (2) @(posedge clk);
        pushExpect(8'h30);
        sendByte(8'h30);
        bus.data_needed = 1'b0;
        @(negedge clk);
        checkOutput("underrun_early", bus.underrun, 1'b0);
        @(negedge clk);
        checkOutput("underrun_pulse", bus.underrun, 1'b1);
        @(negedge clk);
        checkOutput("underrun_width", bus.underrun, 1'b0);
        @(posedge clk);
        #1 bus.data_needed = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.data_needed = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.underrun) pulses++;
        end
        checkOutput("no_underrun_in_read", pulses, 0);
        repeat (BYTE_GAP) @(posedge clk);
        applyStimulus(8'($urandom));
        frameEnd(2);

        $display("[TB] reset mid write burst");
        frameStart();
        applyStimulus(8'h83); applyStimulus(8'($urandom));
        sendByte(8'h99);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_we", bus.reg_we, 1'b0);
        checkOutput("midreset_tx", bus.tx_data, STATUS);
        checkOutput("midreset_busy", bus.busy, 1'b0);
        checkOutput("midreset_addr", bus.reg_addr, 0);
        checkOutput("midreset_wdata", bus.reg_wdata, 8'h00);
        sendByte(8'h55);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sendByte(8'h66);
        repeat (BYTE_GAP) @(posedge clk);
        sendByte(8'h77);
        repeat (BYTE_GAP) @(posedge clk);
        checkOutput("idle_until_reselect", bus.busy, 1'b0);
        frameEnd(2);

        $display("[TB] random frames");
        for (int f = 0; f < 30; f++) begin
            cmd = 8'($urandom);
            n   = $urandom_range(1, 4);
            frameStart();
            applyStimulus(cmd);
            for (int k = 0; k < n; k++) applyStimulus(8'($urandom));
            frameEnd($urandom_range(1, 3));
        end

        repeat (20) @(posedge clk);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Command/response bridge between the byte-level SPI slave and an internal register bus. It parses each SPI frame (one `ssel` low period) as a command byte followed by data bytes. For writes it issues register-bus write strobes. For reads it fetches register data and presents it on `tx_data` ahead of the next byte shift. It sits directly downstream of the SPI slave, consuming `byte_received`/`rx_data`/`data_needed` and driving its `tx_data` input.

## Interface
- `ADDR_W`, 7: register address width; legal range 1..7.
- `STATUS_BYTE`, 8'hA5: value shifted out during the command byte, during write bytes and while idle.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ssel`  in  1  SPI chip select, active-low, same signal the SPI slave sees.
- `byte_received`  in  1  one-cycle pulse from the SPI slave, one per completed byte.
- `rx_data`  in  8  received byte; valid in the `byte_received` cycle.
- `data_needed`  in  1  high while the SPI slave is loading its shift buffer from `tx_data`.
- `tx_data`  out  8  byte for the SPI slave to shift out next.
- `reg_addr`  out  ADDR_W  register bus address.
- `reg_wdata`  out  8  register write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data; valid exactly one cycle after `reg_re`.
- `busy`  out  1  high whenever state != IDLE.
- `underrun`  out  1  one-cycle pulse on a read-path underrun (see Operation).

## Operation
- Command byte format:
  - bit7 = 1 selects write, 0 selects read.
  - bits[ADDR_W-1:0] give the start address.
  - Unused bits are ignored.
- State IDLE:
  - `tx_data` = STATUS_BYTE.
  - `ssel` low: go to CMD.
- State CMD:
  - On `byte_received`: `addr` <= rx_data[ADDR_W-1:0].
  - bit7 = 1: go to WRITE.
  - bit7 = 0: go to RD_REQ.
- State WRITE, on each `byte_received`:
  - `reg_we` = 1 for the next cycle, with `reg_addr` = addr and `reg_wdata` = rx_data.
  - `addr` <= addr+1.
  - `tx_data` stays STATUS_BYTE.
- State RD_REQ:
  - `reg_re` = 1 with `reg_addr` = addr.
  - Go to RD_WAIT.
- State RD_WAIT:
  - `tx_data` <= reg_rdata; `addr` <= addr+1.
  - Go to READ.
- State READ:
  - On `byte_received`: go to RD_REQ. The master's received byte is ignored.
  - Result: the first data byte returns reg[start], the second returns reg[start+1], and so on.
- Address arithmetic: `addr` increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- `ssel` high in any state:
  - Go to IDLE next cycle and set `tx_data` <= STATUS_BYTE.
  - Any `byte_received` or `reg_rdata` in that cycle is discarded; no `reg_we` results.
  - A `reg_re` already issued completes on the bus, but its data is dropped.
- `underrun`:
  - Pulses one cycle when `data_needed` falls (registered compare, 1 -> 0) while state is RD_REQ or RD_WAIT.
  - Meaning: the slave latched `tx_data` before the fetch completed. The frame continues normally.
- Reset, asynchronous and active-low:
  - State = IDLE, `addr` = 0, `tx_data` = STATUS_BYTE.
  - `reg_addr` = 0, `reg_wdata` = 0.
  - `reg_we`, `reg_re`, `busy`, `underrun` = 0.
  - Reset mid-frame aborts the frame; no strobes are emitted after reset release until a new `ssel` falling edge.

## Timing
- `byte_received` in cycle T leads to:
  - WRITE: `reg_we` in T+1.
  - CMD-read or READ: `reg_re` in T+1, `tx_data` updated at the end of T+2, stable from T+3.
- Read turnaround ≤ 3 clk. Requirement on the design: clk ≥ 8× SCK, so `tx_data` is stable before the next SCK rising edge.
- `reg_we` and `reg_re` are never high in the same cycle.
- Each strobe is high for exactly 1 cycle per byte.
- `busy` rises the cycle after `ssel` falls and drops the cycle after `ssel` rises.
- Back-to-back frames with a 1-cycle `ssel` high gap are supported: IDLE is entered, then CMD.

## Test plan
- Write burst: `ssel` low, bytes 0x85, 0x11, 0x22, then `ssel` high.
  - Required: `reg_we` pulses with (addr 5, 0x11), then (addr 6, 0x22).
  - `tx_data` stays 0xA5 throughout. No `reg_re`.
- Read burst: reg[0x10]=0x3C, reg[0x11]=0x4D; bytes 0x10, 0x00, 0x00.
  - Required: `reg_re` at addr 0x10, then 0x11, then 0x12.
  - `tx_data` = 0x3C within 3 clk of the first `byte_received`, then 0x4D.
- Wrap: write command 0xFF, then 2 data bytes.
  - Required: writes go to addr 0x7F, then 0x00.
- Abort: `ssel` rises in the RD_WAIT cycle.
  - Required: next cycle state is IDLE, `tx_data` = 0xA5, `busy` = 0.
  - The next frame's command byte is parsed normally.
- Underrun: force `data_needed` 1 -> 0 during RD_REQ.
  - Required: `underrun` pulses exactly 1 cycle.
  - `data_needed` falling in READ gives no pulse.
- Reset: assert `rst_n` = 0 mid write burst.
  - Required: all outputs take their reset values immediately, with no further `reg_we`.
  - `tx_data` = 0xA5.
